// File: rtl/fsm_arbiter_amisha_pkg.sv
// Shared types for the two-requester arbiter.
package fsm_arbiter_amisha_pkg;

`include "fsm_arbiter_defs_amisha.vh"

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        GNT0 = ST_GNT0,
        GNT1 = ST_GNT1
    } state_t;

endpackage

// File: rtl/fsm_arbiter_amisha_hold_cnt.sv
// Hold counter: clear has priority, counts up while enabled, sticks at MAX-1.
module hold_cnt_amisha #(
    parameter int MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] count
);

    localparam logic [3:0] TOP = 4'(MAX - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (enable && (count != TOP)) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/fsm_arbiter_defs_amisha.vh
// State encodings and default hold limit shared by the arbiter files.
`ifndef FSM_ARBITER_DEFS_AMISHA_VH
`define FSM_ARBITER_DEFS_AMISHA_VH

localparam logic [1:0] ST_IDLE = 2'b00;
localparam logic [1:0] ST_GNT0 = 2'b01;
localparam logic [1:0] ST_GNT1 = 2'b10;
localparam int MAX_HOLD_DEF = 4;

`endif

// File: rtl/fsm_arbiter_amisha.sv
// Two-requester arbiter with alternating tie-break and bounded hold time.
module fsm_arbiter_amisha
    import fsm_arbiter_amisha_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic clk_amisha,
    input  logic reset_amisha,
    input  logic r0_amisha,
    input  logic r1_amisha,
    output logic g0_amisha,
    output logic g1_amisha,
    output logic busy_amisha,
    output logic preempt_amisha
);

    localparam logic [3:0] HOLD_TOP = 4'(MAX_HOLD - 1);

    state_t     state;
    state_t     next_state;
    logic       last_amisha;
    logic       next_last;
    logic       preempt_next;
    logic       entry;
    logic       in_grant;
    logic       sat;
    logic [3:0] hold_count;

    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            state          <= IDLE;
            last_amisha    <= 1'b1;
            preempt_amisha <= 1'b0;
        end else begin
            state          <= next_state;
            last_amisha    <= next_last;
            preempt_amisha <= preempt_next;
        end
    end

    assign sat      = (hold_count == HOLD_TOP);
    assign in_grant = (state == GNT0) || (state == GNT1);

    always_comb begin
        next_state   = state;
        preempt_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (r0_amisha && r1_amisha) begin
                    next_state = last_amisha ? GNT0 : GNT1;
                end else if (r0_amisha) begin
                    next_state = GNT0;
                end else if (r1_amisha) begin
                    next_state = GNT1;
                end
            end
            GNT0: begin
                if (!r0_amisha) begin
                    next_state = r1_amisha ? GNT1 : IDLE;
                end else if (r1_amisha && sat) begin
                    next_state   = GNT1;
                    preempt_next = 1'b1;
                end
            end
            GNT1: begin
                if (!r1_amisha) begin
                    next_state = r0_amisha ? GNT0 : IDLE;
                end else if (r0_amisha && sat) begin
                    next_state   = GNT0;
                    preempt_next = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Any move into a grant state restarts the hold window.
    always_comb begin
        entry     = (next_state != state) && (next_state != IDLE);
        next_last = last_amisha;
        if (entry) begin
            next_last = (next_state == GNT1);
        end
    end

    hold_cnt_amisha #(
        .MAX(MAX_HOLD)
    ) u_hold (
        .clk   (clk_amisha),
        .reset (reset_amisha),
        .clear (entry),
        .enable(in_grant),
        .count (hold_count)
    );

    assign g0_amisha   = (state == GNT0);
    assign g1_amisha   = (state == GNT1);
    assign busy_amisha = g0_amisha | g1_amisha;

endmodule

// File: tb/tb_fsm_arbiter_amisha.sv
// Vector-table bench for fsm_arbiter_amisha with MAX_HOLD=4.
module tb_fsm_arbiter_amisha;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r0  = 1'b0;
    logic r1  = 1'b0;
    logic g0;
    logic g1;
    logic busy;
    logic pre;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic       r0;
        logic       r1;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    always #50 clk = ~clk;

    fsm_arbiter_amisha #(
        .MAX_HOLD(4)
    ) dut (
        .clk_amisha    (clk),
        .reset_amisha  (rst),
        .r0_amisha     (r0),
        .r1_amisha     (r1),
        .g0_amisha     (g0),
        .g1_amisha     (g1),
        .busy_amisha   (busy),
        .preempt_amisha(pre)
    );

    // exp = {g0, g1, busy, preempt} visible after the edge that samples the row
    function automatic void add(input logic rs, input logic a, input logic b,
                                input logic [3:0] e, input string n);
        vec_t v;
        v.rst  = rs;
        v.r0   = a;
        v.r1   = b;
        v.exp  = e;
        v.name = n;
        tbl.push_back(v);
    endfunction

    initial begin
        vec_t v;
        vec_t e;
        logic [3:0] got;

        add(1, 1, 1, 4'b0000, "reset_hold_a");
        add(1, 1, 1, 4'b0000, "reset_hold_b");
        add(0, 1, 1, 4'b1010, "first_tie_r0");
        for (int i = 0; i < 9; i++) add(0, 1, 0, 4'b1010, "r0_alone_hold");
        add(0, 0, 0, 4'b0000, "r0_release_idle");
        add(0, 1, 1, 4'b0110, "tie_after_g0");
        for (int i = 0; i < 3; i++) add(0, 1, 1, 4'b0110, "g1_window");
        add(0, 1, 1, 4'b1011, "preempt_to_g0");
        for (int i = 0; i < 3; i++) add(0, 1, 1, 4'b1010, "g0_window");
        add(0, 1, 1, 4'b0111, "preempt_to_g1");
        add(0, 1, 0, 4'b1010, "r1_drop_handoff");
        add(1, 1, 0, 4'b0000, "reset_mid_g0");
        add(0, 0, 1, 4'b0110, "post_reset_r1");
        add(0, 0, 0, 4'b0000, "r1_release");
        add(0, 1, 1, 4'b1010, "joint_req_g0");
        for (int i = 0; i < 3; i++) add(0, 1, 1, 4'b1010, "joint_g0_hold");
        add(0, 1, 1, 4'b0111, "joint_pre_g1");
        for (int i = 0; i < 3; i++) add(0, 1, 1, 4'b0110, "joint_g1_hold");
        add(0, 1, 1, 4'b1011, "joint_pre_g0");
        add(0, 0, 0, 4'b0000, "joint_release");
        add(0, 1, 0, 4'b1010, "pulse_base_g0");
        add(0, 1, 1, 4'b1010, "r1_pulse_early");
        for (int i = 0; i < 4; i++) add(0, 1, 0, 4'b1010, "pulse_ignored");
        add(0, 1, 1, 4'b0111, "sat_then_pre");
        add(0, 0, 0, 4'b0000, "all_release");
        add(1, 0, 1, 4'b0000, "reset_ignores_r1");
        add(1, 1, 1, 4'b0000, "reset_ignores_both");
        add(0, 0, 1, 4'b0110, "resume_r1");
        add(0, 0, 0, 4'b0000, "final_idle");

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            rst = v.rst;
            r0  = v.r0;
            r1  = v.r1;
            sb.push_back(v);
            @(posedge clk);
            #1;
            got = {g0, g1, busy, pre};
            e   = sb.pop_front();
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s row=%0d got g0g1bp=%b expected %b",
                         e.name, i, got, e.exp);
            end
        end

        // Multi-cycle sequence: saturated hold with only r0, then r1 arrives late.
        @(negedge clk);
        rst = 1'b0;
        r0  = 1'b1;
        r1  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({g0, g1, pre} !== 3'b100) begin
                errors++;
                $display("FAIL long_hold cyc=%0d got g0g1p=%b expected 100",
                         c, {g0, g1, pre});
            end
        end
        @(negedge clk);
        r1 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({g0, g1, pre} !== 3'b011) begin
            errors++;
            $display("FAIL late_r1_preempt got g0g1p=%b expected 011",
                     {g0, g1, pre});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({g0, g1, pre} !== 3'b010) begin
            errors++;
            $display("FAIL preempt_one_cycle got g0g1p=%b expected 010",
                     {g0, g1, pre});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsm_arbiter_amisha.md
FSM_ARBITER_AMISHA -- requirements
Module: fsm_arbiter_amisha

Interface
- REQ-001 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles while the other requester waits; legal range 2..15.
- REQ-002 clk_amisha  input  1  single clock; all state updates on its rising edge.
- REQ-003 reset_amisha  input  1  reset, synchronous and active-high.
- REQ-004 r0_amisha  input  1  request from requester 0; level, held until done.
- REQ-005 r1_amisha  input  1  request from requester 1; level, held until done.
- REQ-006 g0_amisha  output  1  grant to requester 0; Moore, decoded from state.
- REQ-007 g1_amisha  output  1  grant to requester 1; Moore, decoded from state.
- REQ-008 busy_amisha  output  1  high whenever either grant is high.
- REQ-009 preempt_amisha  output  1  one-cycle registered pulse on a forced grant switch.

Function
- REQ-010 The FSM SHALL have three states: IDLE, GNT0, GNT1; g0_amisha SHALL be high only in GNT0, and g1_amisha only in GNT1.
- REQ-011 g0_amisha and g1_amisha SHALL never be high in the same cycle.
- REQ-012 A 1-bit register last_amisha SHALL record the most recently granted requester; it updates on every entry to GNT0 (value 0) or GNT1 (value 1).
- REQ-013 IDLE, only r0 high -> GNT0; only r1 high -> GNT1; both high -> the requester not equal to last_amisha; neither high -> stay in IDLE.
- REQ-014 Grant latency SHALL be one cycle: a request sampled at edge k gives a grant visible after edge k.
- REQ-015 A hold counter SHALL clear to 0 on every entry to GNT0/GNT1 and increment once per cycle in the grant state, saturating at MAX_HOLD-1.
- REQ-016 GNTx with rx low: if the other requester is high, go directly to GNT(other) with no idle cycle; otherwise go to IDLE.
- REQ-017 GNTx with rx high and the other requester low: stay in GNTx indefinitely, with the counter saturated and no preemption.
- REQ-018 GNTx with rx high, the other requester high and counter == MAX_HOLD-1: go to GNT(other) and assert preempt_amisha for exactly the first cycle of the new grant.
- REQ-019 A requester preempted while still requesting SHALL be granted directly when the new holder releases, or when the new holder is itself preempted.
- REQ-020 Requests are not latched: a request pulse that drops before it is granted SHALL be ignored.
- REQ-021 busy_amisha SHALL equal g0_amisha OR g1_amisha.

Reset
- REQ-022 When reset_amisha is sampled high: state = IDLE, counter = 0, last_amisha = 1 (requester 0 wins the first tie), and all outputs = 0 after that edge.
- REQ-023 Reset asserted mid-grant SHALL drop the grant after the sampling edge; reset has priority over all transitions.
- REQ-024 While reset is held, requests SHALL be ignored; arbitration resumes at the first edge with reset low.

Structure
- REQ-025 The state encodings (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10) and the MAX_HOLD default SHALL live in a shared include file, fsm_arbiter_defs_amisha.vh.
- REQ-026 The design SHALL use a two-segment style: a state/last/counter register block plus a combinational next-state block.
- REQ-027 The hold counter SHALL be a sub-module, hold_cnt_amisha, with clear, enable and saturate-at-max behaviour.

Verification (MAX_HOLD=4, 100 ns clock)
- REQ-028 Reset 2 cycles with r0=r1=1 -> g0=g1=0; release reset -> g0=1 after the first edge; preempt=0.
- REQ-029 r0 alone for 10 cycles -> g0 high 10 consecutive cycles, no preempt; r0 drops -> g0=0 and busy=0 the next cycle.
- REQ-030 r0 granted, r1 raised at the same time and both held -> g0 high exactly 4 cycles, then g1 with a 1-cycle preempt=1; after 4 more cycles, back to g0 with preempt=1.
- REQ-031 From IDLE, r0=r1=1 rising together after a grant to requester 0 -> g1 granted first.
- REQ-032 In GNT1, r1 drops while r0 is high -> g0=1 on the very next cycle, preempt=0.
- REQ-033 Reset asserted during GNT0 -> g0=0 after the edge; after release with r1 only -> g1=1 one cycle later.
